// File: rtl/spi_slave.sv
// SPI slave: oversampled in the clk domain, all four cpol/cpha modes, LSB first.
// One-frame transmit buffer with ready/valid load; received frames are
// presented on rx_data with a single-cycle rx_valid pulse (no backpressure).
module spi_slave #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    input  logic             cpol,
    input  logic             cpha,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic               sclk_s1, sclk_s2, sclk_d;
    logic               cs_s1, cs_s2, cs_d;
    logic               mosi_s1, mosi_s2;

    logic               cpol_q, cpha_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-1:0]   rx_shift;
    logic [WIDTH-1:0]   tx_shift;
    logic [WIDTH-1:0]   tx_buf;
    logic               tx_buf_full;

    logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic               lead_edge, trail_edge;
    logic               in_shift, sample_edge, shift_edge, last_sample;
    logic               tx_load;
    logic [WIDTH-1:0]   rx_next;

    assign sclk_rise  = sclk_s2 & ~sclk_d;
    assign sclk_fall  = ~sclk_s2 & sclk_d;
    assign cs_rise    = cs_s2 & ~cs_d;
    assign cs_fall    = ~cs_s2 & cs_d;

    assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge = cpol_q ? sclk_rise : sclk_fall;

    assign in_shift    = (state_q == SHIFT);
    assign sample_edge = in_shift & (cpha_q ? trail_edge : lead_edge);
    // A shift edge before the first sample of a frame belongs either to the
    // cpha=1 preamble (bit 0 is already on miso) or to the tail of the
    // previous back-to-back frame, so it must not move the new frame.
    assign shift_edge  = in_shift & (cpha_q ? lead_edge : trail_edge) & (bit_cnt != '0);
    assign last_sample = sample_edge & (bit_cnt == LAST_BIT);
    assign rx_next     = {mosi_s2, rx_shift[WIDTH-1:1]};

    assign tx_ready = ~tx_buf_full;
    assign tx_load  = tx_valid & tx_ready;
    assign miso_oe  = ~cs_s2 & (state_q != IDLE);
    assign miso     = miso_oe & tx_shift[0];

    // Two-flop synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_s1 <= cpol;
            sclk_s2 <= cpol;
            sclk_d  <= cpol;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a deselect overrides everything and aborts the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_sample) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    // Control: mode capture, bit counter, buffer flag and output pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            tx_buf_full <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            if (tx_load) begin
                tx_buf_full <= 1'b1;
            end else if (state_q == LOAD) begin
                tx_buf_full <= 1'b0;
            end
            case (state_q)
                LOAD: begin
                    cpol_q      <= cpol;
                    cpha_q      <= cpha;
                    bit_cnt     <= '0;
                    tx_underrun <= ~tx_buf_full;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (!cs_rise) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

    // Datapath: transmit buffer and the two shift registers.
    always_ff @(posedge clk) begin
        if (tx_load) begin
            tx_buf <= tx_data;
        end
        if (state_q == LOAD) begin
            tx_shift <= tx_buf_full ? tx_buf : {WIDTH{1'b1}};
        end else if (shift_edge) begin
            tx_shift <= {1'b0, tx_shift[WIDTH-1:1]};
        end
        if (sample_edge) begin
            rx_shift <= rx_next;
        end
    end

endmodule
